div3_seq_ctrl: RTL

//  Sequencer around one diff_even_odd instance for iterative divisibility-by-3 checking.

---
 rtl/div3_seq_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/div3_seq_ctrl.sv
// Iterative divisibility-by-3 sequencer: an operand is folded through diff_even_odd until it is below 4.
// Optional reduce-step reporting on out_iters is built only when DIV3_ITER_CNT_EN is defined.

module diff_even_odd #(
  parameter int DATA_LEN = 8,
  parameter int HALF_LEN = 4
) (
  input  logic [DATA_LEN-1:0] data,
  output logic [DATA_LEN-1:0] diff
);

  logic [DATA_LEN-1:0] even_cnt;
  logic [DATA_LEN-1:0] odd_cnt;

  // Weight 2 is -1 mod 3, so |even ones - odd ones| keeps the residue class of 0.
  always_comb begin
    even_cnt = '0;
    odd_cnt  = '0;
    for (int i = 0; i < HALF_LEN; i++) begin
      even_cnt = even_cnt + DATA_LEN'(data[2*i]);
      odd_cnt  = odd_cnt  + DATA_LEN'(data[2*i+1]);
    end
    diff = (even_cnt >= odd_cnt) ? (even_cnt - odd_cnt) : (odd_cnt - even_cnt);
  end

endmodule

module div3_seq_ctrl #(
  parameter int DATA_LEN = 8,
  parameter int HALF_LEN = 4,
  parameter int MAX_ITER = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_LEN-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_div3,
  output logic                out_err,
  output logic [3:0]          out_iters
);

  typedef enum logic [1:0] {
    IDLE,
    REDUCE,
    DONE
  } state_t;

  localparam logic [3:0] MAX_ITER_C = 4'(MAX_ITER);

  state_t              state;
  logic [DATA_LEN-1:0] acc;
  logic [DATA_LEN-1:0] acc_diff;
  logic [3:0]          iter;
  logic                acc_small;
  logic                finish_step;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == MAX_ITER_C) ? v : v + 4'd1;
  endfunction

  diff_even_odd #(
    .DATA_LEN (DATA_LEN),
    .HALF_LEN (HALF_LEN)
  ) u_diff (
    .data (acc),
    .diff (acc_diff)
  );

  assign acc_small   = (acc[DATA_LEN-1:2] == '0);
  assign finish_step = (state == REDUCE) && (acc_small || (iter == MAX_ITER_C));
  assign in_ready    = rst_n && (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      iter      <= '0;
      out_valid <= 1'b0;
      out_div3  <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc   <= in_data;
            iter  <= '0;
            state <= REDUCE;
          end
        end
        REDUCE: begin
          if (acc_small) begin
            out_div3  <= (acc == '0) || (acc == DATA_LEN'(3));
            out_err   <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (iter == MAX_ITER_C) begin
            out_div3  <= 1'b0;
            out_err   <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            acc  <= acc_diff;
            iter <= sat_inc(iter);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_div3  <= 1'b0;
            out_err   <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DIV3_ITER_CNT_EN
  logic [3:0] iters_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      iters_q <= '0;
    end else if (finish_step) begin
      iters_q <= iter;
    end else if ((state == DONE) && out_ready) begin
      iters_q <= '0;
    end
  end

  assign out_iters = iters_q;
`else
  logic unused_finish;
  assign unused_finish = finish_step;
  assign out_iters     = 4'd0;
`endif

endmodule
